cpu_clk_ctrl: RTL and testbench

Run/step controller for the pipelined CPU's clock on the FPGA board. It replaces free-running divided clocks with a single-cycle clock-enable pulse, `cpu_ce`, generated on the system clock. The pulse supports fast run, slow run, debounced single-step, and stop-on-halt. It sits between the board switches/buttons and the CPU pipeline registers, which advance only when `cpu_ce` is high.

---
 rtl/cpu_clk_pkg.sv | 19 +
 rtl/cpu_clk_ctrl_btn_debounce.sv | 57 +++++
 rtl/cpu_clk_ctrl.sv | 118 +++++++++++
 tb/tb_cpu_clk_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_pkg.sv
// Shared state encoding and default divisors for the CPU clock-enable controller.
// Used by the controller, the CPU top and the board display logic; no timing of its own.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } cpu_clk_state_e;

    localparam int unsigned FAST_DIV_DEF   = 31;
    localparam int unsigned SLOW_DIV_DEF   = 2500001;
    localparam int unsigned DEB_CYCLES_DEF = 1000000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability debounce, one-cycle rise pulse.
// rise_o lands 2 (sync) + DEB_CYCLES + 1 cycles after the press is first sampled; no backpressure.
module btn_debounce
    import cpu_clk_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic db_o,
    output logic rise_o
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;
    logic          db_prev_q;
    logic          rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[0], btn_i};
        db_d   = db_q;
        cnt_d  = '0;
        // The level only flips once the counter has confirmed a full stable window.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CW'(DEB_CYCLES)) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        rise_d = db_q & ~db_prev_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            rise_q    <= rise_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/step/halt controller producing a one-cycle CPU clock enable from the system clock.
// cpu_ce is registered: P cycles after entering RUN, or one cycle after a debounced step; no backpressure.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int unsigned FAST_DIV   = FAST_DIV_DEF,
    parameter int unsigned SLOW_DIV   = SLOW_DIV_DEF,
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        choose,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        halt_req,
    output logic        cpu_ce,
    output logic        halted,
    output logic [1:0]  state,
    output logic [31:0] tick_cnt
);

    localparam int unsigned CW = $clog2(max_u(FAST_DIV, SLOW_DIV));

    cpu_clk_state_e state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  period_m1;
    logic           choose_q;
    logic           choose_chg;
    logic           ce_q, ce_d;
    logic [31:0]    tick_q, tick_d;
    logic           step_db;
    logic           step_rise;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_deb (
        .clk_i  (clk_in),
        .rst_ni (rst_n),
        .btn_i  (step_btn),
        .db_o   (step_db),
        .rise_o (step_rise)
    );

    assign choose_chg = (choose != choose_q);
    assign period_m1  = choose_q ? CW'(FAST_DIV - 1) : CW'(SLOW_DIV - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ce_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (run_sw) begin
                    state_d = ST_RUN;
                end else if (step_rise) begin
                    ce_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                    cnt_d   = '0;
                end else if (!run_sw) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (choose_chg) begin
                    cnt_d = '0;
                end else if (cnt_q >= period_m1) begin
                    // >= rather than == so a shrunken period still terminates the count.
                    ce_d  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HALTED: begin
                cnt_d = '0;
                if (!run_sw && !halt_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        tick_d = tick_q + {31'd0, ce_d};
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            choose_q <= 1'b0;
            ce_q     <= 1'b0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            choose_q <= choose;
            ce_q     <= ce_d;
            tick_q   <= tick_d;
        end
    end

    assign cpu_ce   = ce_q;
    assign halted   = (state_q == ST_HALTED);
    assign state    = state_q;
    assign tick_cnt = tick_q;

    // The debounced level itself is only needed by other button users.
    logic unused_db;
    assign unused_db = step_db;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed scenarios plus randomized traffic against an event-time model.
module tb_cpu_clk_ctrl;
    import cpu_clk_pkg::*;

    localparam int FAST = 4;
    localparam int SLOW = 10;
    localparam int DEB  = 3;

    logic        clk_in = 1'b0;
    logic        rst_n, choose, run_sw, step_btn, halt_req;
    logic        cpu_ce, halted;
    logic [1:0]  state;
    logic [31:0] tick_cnt;

    int n_checks = 0;
    int n_errors = 0;

    cpu_clk_ctrl #(
        .FAST_DIV   (FAST),
        .SLOW_DIV   (SLOW),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .choose   (choose),
        .run_sw   (run_sw),
        .step_btn (step_btn),
        .halt_req (halt_req),
        .cpu_ce   (cpu_ce),
        .halted   (halted),
        .state    (state),
        .tick_cnt (tick_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pulses are scheduled as absolute due cycles, the button is judged
    // from a history of raw samples (a press counts once DEB+1 consecutive synchronized
    // samples disagree with the debounced level).
    int          m_cyc = 0;
    int          m_mode = 0;
    int          m_due = 0;
    int          m_flip_at = -100;
    logic        m_ce = 1'b0;
    logic [31:0] m_tick = '0;
    logic        m_choose = 1'b0;
    logic        m_db = 1'b0;
    bit          m_force_tick = 1'b0;
    bit          model_on = 1'b0;
    bit          raw_hist[$];
    bit          m_rise, m_all_diff, m_chg;
    int          m_p;

    always @(posedge clk_in) begin
        m_cyc++;
        m_rise = (m_flip_at == m_cyc - 2);
        raw_hist.push_front(step_btn);
        if (raw_hist.size() > 8) void'(raw_hist.pop_back());
        if (!rst_n) begin
            m_mode    = 0;
            m_ce      = 1'b0;
            m_tick    = '0;
            m_choose  = 1'b0;
            m_db      = 1'b0;
            m_flip_at = -100;
            raw_hist  = {};
            repeat (8) raw_hist.push_front(1'b0);
        end else begin
            m_all_diff = 1'b1;
            for (int k = 2; k <= DEB + 2; k++) if (raw_hist[k] == m_db) m_all_diff = 1'b0;
            if (m_all_diff) begin
                m_db = !m_db;
                if (m_db) m_flip_at = m_cyc;
            end
            m_chg    = (choose != m_choose);
            m_choose = choose;
            m_p      = m_choose ? FAST : SLOW;
            m_ce     = 1'b0;
            case (m_mode)
                0: begin
                    if (halt_req) m_mode = 2;
                    else if (run_sw) begin
                        m_mode = 1;
                        m_due  = m_cyc + m_p;
                    end else if (m_rise) m_ce = 1'b1;
                end
                1: begin
                    if (halt_req) m_mode = 2;
                    else if (!run_sw) m_mode = 0;
                    else if (m_chg) m_due = m_cyc + m_p;
                    else if (m_cyc == m_due) begin
                        m_ce  = 1'b1;
                        m_due = m_cyc + m_p;
                    end
                end
                default: begin
                    if (!run_sw && !halt_req) m_mode = 0;
                end
            endcase
            if (m_force_tick) m_tick = 32'hFFFF_FFFF;
            else m_tick = m_tick + {31'd0, m_ce};
        end
    end

    always @(negedge clk_in) begin
        if (model_on) begin
            check_eq("cyc_ce", {31'd0, cpu_ce}, {31'd0, m_ce});
            check_eq("cyc_state", {30'd0, state}, 32'(m_mode));
            check_eq("cyc_halted", {31'd0, halted}, (m_mode == 2) ? 32'd1 : 32'd0);
            check_eq("cyc_tick", tick_cnt, m_tick);
        end
    end

    // Counts falling edges until cpu_ce is seen high; -1 on timeout.
    task automatic edges_to_ce(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (cpu_ce !== 1'b1 && n < limit);
        if (cpu_ce !== 1'b1) n = -1;
    endtask

    // Holds step_btn high for hold edges, then counts pulses over a fixed window.
    task automatic press_step(input int hold, output int first, output int pulses);
        first  = -1;
        pulses = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_in);
            if (i == hold) step_btn = 1'b0;
            if (cpu_ce === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
    endtask

    int n, first, pulses, btn_left;

    initial begin
        rst_n = 1'b0; choose = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
        repeat (2) @(negedge clk_in);
        model_on = 1'b1;
        check_eq("rst_state", {30'd0, state}, 32'(ST_IDLE));
        check_eq("rst_ce", {31'd0, cpu_ce}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_tick", tick_cnt, 32'd0);
        rst_n = 1'b1;

        // Fast run: state registers one edge after the request, then P edges to the pulse.
        choose = 1'b1; run_sw = 1'b1;
        edges_to_ce(30, n); check_eq("fast_first", n, FAST + 1);
        for (int i = 0; i < 4; i++) begin
            edges_to_ce(30, n); check_eq("fast_gap", n, FAST);
        end
        check_eq("fast_tick5", tick_cnt, 32'd5);

        // Rate switching clears the count.
        choose = 1'b0;
        edges_to_ce(40, n); check_eq("slow_first", n, SLOW + 1);
        edges_to_ce(40, n); check_eq("slow_gap", n, SLOW);
        repeat (5) @(negedge clk_in);
        choose = 1'b1;
        edges_to_ce(40, n); check_eq("switch_fast", n, FAST + 1);
        choose = 1'b0;
        edges_to_ce(40, n); check_eq("switch_slow", n, SLOW + 1);
        edges_to_ce(40, n); check_eq("switch_slow_gap", n, SLOW);

        // Leaving run stops pulses.
        run_sw = 1'b0;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_in);
            if (cpu_ce === 1'b1) pulses++;
        end
        check_eq("idle_no_ce", pulses, 0);
        check_eq("idle_state", {30'd0, state}, 32'(ST_IDLE));

        // Single step and glitch rejection.
        press_step(6, first, pulses);
        check_eq("step_latency", first, 1 + 2 + DEB + 1 + 1);
        check_eq("step_count", pulses, 1);
        press_step(2, first, pulses);
        check_eq("glitch_count", pulses, 0);

        // Halt on the cycle before a due pulse.
        choose = 1'b1; run_sw = 1'b1;
        edges_to_ce(30, n); check_eq("halt_pre_first", n, FAST + 1);
        repeat (FAST - 1) @(negedge clk_in);
        halt_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            if (cpu_ce === 1'b1) pulses++;
        end
        check_eq("halt_no_ce", pulses, 0);
        check_eq("halt_state", {30'd0, state}, 32'(ST_HALTED));
        check_eq("halt_flag", {31'd0, halted}, 32'd1);
        halt_req = 1'b0;
        repeat (5) @(negedge clk_in);
        check_eq("halt_hold", {30'd0, state}, 32'(ST_HALTED));
        run_sw = 1'b0;
        @(negedge clk_in);
        check_eq("halt_exit", {30'd0, state}, 32'(ST_IDLE));
        check_eq("halt_exit_flag", {31'd0, halted}, 32'd0);

        // Reset in the middle of a period.
        run_sw = 1'b1;
        edges_to_ce(30, n); check_eq("mid_first", n, FAST + 1);
        repeat (2) @(negedge clk_in);
        rst_n = 1'b0;
        @(negedge clk_in);
        check_eq("mid_rst_state", {30'd0, state}, 32'd0);
        check_eq("mid_rst_ce", {31'd0, cpu_ce}, 32'd0);
        check_eq("mid_rst_tick", tick_cnt, 32'd0);
        rst_n = 1'b1;
        edges_to_ce(30, n); check_eq("post_rst_first", n, FAST + 1);

        // Counter wrap on a single step.
        run_sw = 1'b0;
        repeat (3) @(negedge clk_in);
        force dut.tick_d = 32'hFFFF_FFFF;
        m_force_tick = 1'b1;
        @(negedge clk_in);
        release dut.tick_d;
        m_force_tick = 1'b0;
        check_eq("wrap_pre", tick_cnt, 32'hFFFF_FFFF);
        press_step(6, first, pulses);
        check_eq("wrap_count", pulses, 1);
        check_eq("wrap_tick", tick_cnt, 32'd0);

        // Randomized traffic, judged cycle by cycle against the model.
        btn_left = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_in);
            if ($urandom_range(0, 39) == 0) run_sw = !run_sw;
            if ($urandom_range(0, 29) == 0) choose = !choose;
            halt_req = ($urandom_range(0, 149) == 0) ? 1'b1 : (halt_req && ($urandom_range(0, 3) != 0));
            if (btn_left > 0) btn_left--;
            else if ($urandom_range(0, 7) == 0) begin
                step_btn = !step_btn;
                btn_left = $urandom_range(0, 7);
            end
            rst_n = ($urandom_range(0, 399) != 0);
        end
        rst_n = 1'b1;
        @(negedge clk_in);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
